// File: rtl/fxp_sumsq_acc.sv
// fxp_sumsq_acc
// Frame-based sum-of-squares accumulator for signed fixed-point samples.
// Each sample is squared in a registered first stage. The squares are
// accumulated until i_last closes the frame. The frame total is then
// reduced to WOI.WOF format (rounded or truncated), saturated to the
// largest non-negative value, and presented with a one-cycle o_valid pulse.
//
// Ports:
//   clk      - rising-edge clock
//   rst      - asynchronous active-low reset
//   i_valid  - in / i_last valid this cycle
//   i_last   - sample closes the current frame (ignored when i_valid=0)
//   in       - signed WII.WIF sample
//   o_valid  - one-cycle pulse, new frame result on out / overflow
//   out      - frame sum of squares, WOI.WOF, MSB always 0
//   overflow - result was saturated
module fxp_sumsq_acc #(
  parameter int WII   = 8,
  parameter int WIF   = 8,
  parameter int WOI   = 9,
  parameter int WOF   = 10,
  parameter int LENW  = 8,
  parameter int ROUND = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  input  logic                 i_last,
  input  logic [WII+WIF-1:0]   in,
  output logic                 o_valid,
  output logic [WOI+WOF-1:0]   out,
  output logic                 overflow
);

  localparam int WIN  = WII + WIF;
  localparam int WSQ  = 2 * WIN;
  localparam int WACC = WSQ + LENW;
  localparam int WOUT = WOI + WOF;
  localparam int SHR  = (WOF >= 2 * WIF) ? 0 : 2 * WIF - WOF;
  localparam int SHL  = (WOF >= 2 * WIF) ? WOF - 2 * WIF : 0;
  localparam int WCVA = WACC + SHL + 1;
  localparam int WCV  = (WCVA > WOUT + 1) ? WCVA : WOUT + 1;
  localparam logic [WCV-1:0] MAX_CV = (WCV'(1) << (WOUT - 1)) - WCV'(1);

  logic             sq_v_q, sq_v_d;
  logic             sq_last_q, sq_last_d;
  logic [WSQ-1:0]   sq_r_q, sq_r_d;
  logic [WACC-1:0]  acc_q, acc_d;
  logic             acc_sat_q, acc_sat_d;
  logic             o_valid_q, o_valid_d;
  logic [WOUT-1:0]  out_q, out_d;
  logic             ovf_q, ovf_d;

  logic [WIN-1:0]   mag;
  logic [WACC:0]    sum_ext;
  logic             carry;
  logic [WACC-1:0]  sum;
  logic [WCV-1:0]   cv;
  logic             cv_ovf;

  // Squaring the magnitude keeps the most negative input exact:
  // its magnitude 2^(WIN-1) still fits in WIN unsigned bits.
  always_comb begin
    mag = in[WIN-1] ? (~in + WIN'(1)) : in;
  end

  always_comb begin
    sum_ext = {1'b0, acc_q} + (WACC + 1)'(sq_r_q);
    carry   = sum_ext[WACC];
    sum     = carry ? '1 : sum_ext[WACC-1:0];
  end

  // Fraction reduction; the rounding carry is added before the range check.
  if (SHR > 0) begin : g_shr
    always_comb begin
      cv = WCV'(sum >> SHR);
      if (ROUND != 0) begin
        cv = cv + WCV'(sum[SHR-1]);
      end
    end
  end else begin : g_shl
    always_comb begin
      cv = WCV'(sum) << SHL;
    end
  end

  always_comb begin
    cv_ovf = acc_sat_q | carry | (cv > MAX_CV);
  end

  always_comb begin
    sq_v_d    = i_valid;
    sq_last_d = i_valid & i_last;
    sq_r_d    = WSQ'(mag) * WSQ'(mag);
    acc_d     = acc_q;
    acc_sat_d = acc_sat_q;
    o_valid_d = 1'b0;
    out_d     = out_q;
    ovf_d     = ovf_q;
    if (sq_v_q) begin
      if (!sq_last_q) begin
        acc_d     = sum;
        acc_sat_d = acc_sat_q | carry;
      end else begin
        // Clearing on the edge that consumes the last square lets the next
        // frame's first square land on a zero accumulator one edge later.
        acc_d     = '0;
        acc_sat_d = 1'b0;
        o_valid_d = 1'b1;
        out_d     = cv_ovf ? MAX_CV[WOUT-1:0] : cv[WOUT-1:0];
        ovf_d     = cv_ovf;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sq_v_q    <= 1'b0;
      sq_last_q <= 1'b0;
      sq_r_q    <= '0;
      acc_q     <= '0;
      acc_sat_q <= 1'b0;
      o_valid_q <= 1'b0;
      out_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      sq_v_q    <= sq_v_d;
      sq_last_q <= sq_last_d;
      sq_r_q    <= sq_r_d;
      acc_q     <= acc_d;
      acc_sat_q <= acc_sat_d;
      o_valid_q <= o_valid_d;
      out_q     <= out_d;
      ovf_q     <= ovf_d;
    end
  end

  assign o_valid  = o_valid_q;
  assign out      = out_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_fxp_sumsq_acc.sv
// Testbench for fxp_sumsq_acc: two instances (ROUND=1 and ROUND=0) share
// one stimulus stream. A frame-level model pushes expected results into a
// scoreboard queue; a monitor pops and compares on each o_valid pulse.
module tb_fxp_sumsq_acc;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_last = 1'b0;
  logic [15:0] din = '0;
  logic        ov_r, ov_t;
  logic [18:0] out_r, out_t;
  logic        ovf_r, ovf_t;

  int unsigned total = 0;
  int unsigned passed = 0;
  int          cyc = 0;
  longint      part_sum = 0;

  typedef struct {
    logic [18:0] o_r;
    logic        f_r;
    logic [18:0] o_t;
    logic        f_t;
    int          cyc;
  } exp_t;
  exp_t q[$];

  fxp_sumsq_acc #(.WII(8), .WIF(8), .WOI(9), .WOF(10), .LENW(8), .ROUND(1)) dut_r (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_last(i_last), .in(din),
    .o_valid(ov_r), .out(out_r), .overflow(ovf_r)
  );

  fxp_sumsq_acc #(.WII(8), .WIF(8), .WOI(9), .WOF(10), .LENW(8), .ROUND(0)) dut_t (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_last(i_last), .in(din),
    .o_valid(ov_t), .out(out_t), .overflow(ovf_t)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Sum of squares in units of 2^-16, reduced to units of 2^-10 and clamped.
  function automatic logic [19:0] conv(input longint s, input bit rnd);
    longint v;
    v = rnd ? (s + 32) / 64 : s / 64;
    if (v > 262143) return {1'b1, 19'h3FFFF};
    return {1'b0, 19'(v)};
  endfunction

  task automatic drive(input bit v, input bit l, input logic [15:0] x);
    exp_t e;
    logic [19:0] cr, ct;
    @(negedge clk);
    i_valid = v;
    i_last  = l;
    din     = x;
    if (v) begin
      part_sum += longint'($signed(x)) * longint'($signed(x));
      if (l) begin
        cr = conv(part_sum, 1'b1);
        ct = conv(part_sum, 1'b0);
        e.o_r = cr[18:0]; e.f_r = cr[19];
        e.o_t = ct[18:0]; e.f_t = ct[19];
        e.cyc = cyc + 2;
        q.push_back(e);
        part_sum = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'($urandom_range(0, 1)), 16'($urandom));
  endtask

  function automatic logic [15:0] rand_sample();
    int unsigned r;
    r = $urandom_range(0, 15);
    if (r == 0) return 16'h8000;
    if (r == 1) return 16'h7FFF;
    return 16'($urandom_range(0, 4095) - 2048);
  endfunction

  // Monitor: every pulse must match the head of the scoreboard in time and value.
  always @(negedge clk) begin
    if (rst) begin
      if (q.size() > 0 && q[0].cyc < cyc) begin
        chk("missed_pulse", 0, 1);
        void'(q.pop_front());
      end
      if (ov_r || ov_t) begin
        if (q.size() == 0) begin
          chk("spurious_pulse", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("pulse_both", {ov_r, ov_t}, 2'b11);
          chk("latency", cyc, e.cyc);
          chk("out_round", out_r, e.o_r);
          chk("ovf_round", ovf_r, e.f_r);
          chk("out_trunc", out_t, e.o_t);
          chk("ovf_trunc", ovf_t, e.f_t);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    chk("rst_ovalid", {ov_r, ov_t}, 0);
    chk("rst_out", {out_r, out_t}, 0);
    chk("rst_ovf", {ovf_r, ovf_t}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Two-sample frame: 3.0, 4.0 -> 25.0
    drive(1'b1, 1'b0, 16'h0300);
    drive(1'b1, 1'b1, 16'h0400);
    // Bubbles then single negative sample -> 4.0
    idle(3);
    drive(1'b1, 1'b1, 16'hFE00);
    // Rounding cases
    drive(1'b1, 1'b1, 16'h000B);
    drive(1'b1, 1'b1, 16'h0009);
    // Saturation and recovery
    drive(1'b1, 1'b1, 16'h8000);
    drive(1'b1, 1'b1, 16'h0100);
    // Back-to-back frames
    drive(1'b1, 1'b1, 16'h0100);
    drive(1'b1, 1'b1, 16'h0200);
    drive(1'b1, 1'b0, 16'h0100);
    drive(1'b1, 1'b1, 16'h0100);
    // Mid-frame idle with a stray i_last (must be ignored)
    drive(1'b1, 1'b0, 16'h0200);
    drive(1'b0, 1'b1, 16'h7F00);
    drive(1'b1, 1'b1, 16'h0200);
    idle(4);

    // Reset mid-frame: 5.0, 5.0 discarded, then 1.0L -> 1.0
    drive(1'b1, 1'b0, 16'h0500);
    drive(1'b1, 1'b0, 16'h0500);
    @(negedge clk);
    i_valid = 1'b0;
    i_last  = 1'b0;
    rst     = 1'b0;
    part_sum = 0;
    #1;
    chk("midrst_out", {out_r, out_t}, 0);
    chk("midrst_ovf", {ovf_r, ovf_t}, 0);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 1'b1, 16'h0100);
    idle(4);

    // Random frames with random gaps
    for (int f = 0; f < 300; f++) begin
      int unsigned len;
      len = $urandom_range(1, 8);
      for (int s = 0; s < int'(len); s++) begin
        if ($urandom_range(0, 4) == 0) idle(int'($urandom_range(1, 2)));
        drive(1'b1, s == int'(len) - 1, rand_sample());
      end
      if ($urandom_range(0, 2) == 0) idle(1);
    end

    idle(6);
    chk("scoreboard_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
